// File: rtl/iobuf_hdx_ctrl.sv
// Half-duplex single-wire controller: sends a UART-style byte on a tristate pad,
// then optionally turns the bus around and receives a one-byte response.
module iobuf_hdx_ctrl #(
    parameter int BIT_CYC  = 16,
    parameter int TURN_CYC = 4,
    parameter int TO_CYC   = 1024
) (
    input  logic       C,
    input  logic       R,
    input  logic       START,
    input  logic [7:0] TX_DATA,
    input  logic       RX_EN,
    output logic       PAD_I,
    output logic       PAD_T,
    input  logic       PAD_O,
    output logic       BUSY,
    output logic       DONE,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    output logic       ERR_TIMEOUT,
    output logic       ERR_FRAME
);

    localparam int MAX_A = (BIT_CYC > TURN_CYC) ? BIT_CYC : TURN_CYC;
    localparam int MAX_C = (MAX_A > TO_CYC) ? MAX_A : TO_CYC;
    localparam int CW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    typedef enum logic [3:0] {
        IDLE,
        TX_START,
        TX_BITS,
        TX_STOP,
        TURN,
        RX_WAIT,
        RX_START,
        RX_BITS,
        RX_STOP
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] to_q;
    logic [2:0]    bitIdx_q;
    logic [7:0]    txData_q;
    logic [7:0]    rxShift_q;
    logic [7:0]    rxData_q;
    logic          rxEn_q;
    logic [1:0]    sync_q;
    logic          padI_q;
    logic          padT_q;
    logic          done_q;
    logic          valid_q;
    logic          errTo_q;
    logic          errFr_q;

    logic syncS;
    logic bitEnd;

    assign syncS  = sync_q[1];
    assign bitEnd = (cnt_q == CW'(BIT_CYC - 1));

    always_ff @(posedge C) begin
        if (R) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            to_q      <= '0;
            bitIdx_q  <= '0;
            txData_q  <= '0;
            rxShift_q <= '0;
            rxData_q  <= '0;
            rxEn_q    <= 1'b0;
            sync_q    <= 2'b11;
            padI_q    <= 1'b1;
            padT_q    <= 1'b1;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            errTo_q   <= 1'b0;
            errFr_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], PAD_O};
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            errTo_q <= 1'b0;
            errFr_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    padT_q <= 1'b1;
                    padI_q <= 1'b1;
                    if (START) begin
                        txData_q <= TX_DATA;
                        rxEn_q   <= RX_EN;
                        cnt_q    <= '0;
                        padT_q   <= 1'b0;
                        padI_q   <= 1'b0;
                        state_q  <= TX_START;
                    end
                end

                TX_START: begin
                    if (bitEnd) begin
                        cnt_q    <= '0;
                        bitIdx_q <= '0;
                        padI_q   <= txData_q[0];
                        state_q  <= TX_BITS;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                // txData_q shifts right so the next bit to send is always in [1]
                TX_BITS: begin
                    if (bitEnd) begin
                        cnt_q <= '0;
                        if (bitIdx_q == 3'd7) begin
                            padI_q  <= 1'b1;
                            state_q <= TX_STOP;
                        end else begin
                            bitIdx_q <= bitIdx_q + 1'b1;
                            padI_q   <= txData_q[1];
                            txData_q <= txData_q >> 1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                TX_STOP: begin
                    if (bitEnd) begin
                        cnt_q  <= '0;
                        padT_q <= 1'b1;
                        padI_q <= 1'b1;
                        to_q   <= '0;
                        if (rxEn_q) begin
                            state_q <= TURN;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                TURN: begin
                    if (cnt_q == CW'(TURN_CYC - 1)) begin
                        cnt_q   <= '0;
                        to_q    <= '0;
                        state_q <= RX_WAIT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                // A start edge wins over an expiring timeout on the same cycle
                RX_WAIT: begin
                    if (!syncS) begin
                        cnt_q   <= '0;
                        state_q <= RX_START;
                    end else if (to_q == CW'(TO_CYC - 1)) begin
                        done_q  <= 1'b1;
                        errTo_q <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        to_q <= to_q + 1'b1;
                    end
                end

                RX_START: begin
                    if (cnt_q == CW'(BIT_CYC / 2)) begin
                        cnt_q <= '0;
                        if (!syncS) begin
                            bitIdx_q <= '0;
                            state_q  <= RX_BITS;
                        end else begin
                            state_q <= RX_WAIT;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                RX_BITS: begin
                    if (bitEnd) begin
                        cnt_q     <= '0;
                        rxShift_q <= {syncS, rxShift_q[7:1]};
                        if (bitIdx_q == 3'd7) begin
                            state_q <= RX_STOP;
                        end else begin
                            bitIdx_q <= bitIdx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                RX_STOP: begin
                    if (bitEnd) begin
                        cnt_q  <= '0;
                        done_q <= 1'b1;
                        if (syncS) begin
                            rxData_q <= rxShift_q;
                            valid_q  <= 1'b1;
                        end else begin
                            errFr_q <= 1'b1;
                        end
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                default: begin
                    padT_q  <= 1'b1;
                    padI_q  <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign PAD_I       = padI_q;
    assign PAD_T       = padT_q;
    assign BUSY        = (state_q != IDLE);
    assign DONE        = done_q;
    assign RX_DATA     = rxData_q;
    assign RX_VALID    = valid_q;
    assign ERR_TIMEOUT = errTo_q;
    assign ERR_FRAME   = errFr_q;

endmodule

// File: tb/tb_iobuf_hdx_ctrl.sv
// Bench for iobuf_hdx_ctrl: a timeline model predicts every output per cycle
// from frame/turnaround/timeout arithmetic, with literal checks on key scenarios.
`timescale 1ns/1ps
module tb_iobuf_hdx_ctrl;

    localparam int BIT  = 16;
    localparam int TURN = 4;
    localparam int TO   = 1024;
    localparam int SYNC = 2;
    localparam int NCYC = 4096;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] txData = 8'h00;
    logic       rxEn = 1'b0;
    logic       padI, padT, padO;
    logic       busy, done, rxValid, errTo, errFr;
    logic [7:0] rxData;
    logic       respLine = 1'b1;

    int cyc = 0;
    int tests = 0;
    int fails = 0;
    bit checkOn = 1'b0;

    int lastDoneCyc = -1;
    int doneCount = 0;
    bit lastValid, lastTo, lastFr;

    logic       expPadT  [NCYC];
    logic       expPadI  [NCYC];
    logic       expBusy  [NCYC];
    logic       expDone  [NCYC];
    logic       expValid [NCYC];
    logic       expTo    [NCYC];
    logic       expFr    [NCYC];
    logic [7:0] expRx    [NCYC];

    logic [14:0] cmpGot, cmpWant;

    // The pad line: the DUT drives it while PAD_T=0, otherwise the responder (idle high)
    assign padO = padT ? respLine : padI;

    iobuf_hdx_ctrl #(.BIT_CYC(BIT), .TURN_CYC(TURN), .TO_CYC(TO)) dut (
        .C(clk), .R(rst), .START(start), .TX_DATA(txData), .RX_EN(rxEn),
        .PAD_I(padI), .PAD_T(padT), .PAD_O(padO), .BUSY(busy), .DONE(done),
        .RX_DATA(rxData), .RX_VALID(rxValid), .ERR_TIMEOUT(errTo), .ERR_FRAME(errFr)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Per-cycle comparison of all outputs against the timeline model
    initial forever begin
        @(negedge clk);
        if (checkOn && cyc < NCYC) begin
            cmpGot  = {padT, padI, busy, done, rxValid, errTo, errFr, rxData};
            cmpWant = {expPadT[cyc], expPadI[cyc], expBusy[cyc], expDone[cyc],
                       expValid[cyc], expTo[cyc], expFr[cyc], expRx[cyc]};
            tests++;
            if (cmpGot !== cmpWant) begin
                fails++;
                $display("[TB] FAIL cycle %0d outputs {T,I,busy,done,valid,to,fr,data}: got %b_%h want %b_%h",
                         cyc, cmpGot[14:8], cmpGot[7:0], cmpWant[14:8], cmpWant[7:0]);
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (done === 1'b1) begin
            lastDoneCyc = cyc;
            lastValid   = rxValid;
            lastTo      = errTo;
            lastFr      = errFr;
            doneCount   = doneCount + 1;
        end
    end

    initial begin
        #(50000 * 10);
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tickUntil(input int n);
        while (cyc < n) tick();
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("[TB] FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic waitDone(input int since, input int limit, input string name);
        int n = 0;
        while (lastDoneCyc <= since && n < limit) begin
            tick();
            n++;
        end
        tests++;
        if (lastDoneCyc <= since) begin
            fails++;
            $display("[TB] FAIL %s: no DONE within %0d cycles", name, limit);
        end
    endtask

    // TX part of a transaction accepted at cycle a: start, 8 data LSB first, stop
    task automatic modelTx(input int a, input logic [7:0] d, input bit withRx);
        logic [9:0] frame;
        frame = {1'b1, d, 1'b0};
        for (int n = a + 1; n <= a + 10 * BIT; n++) begin
            expPadT[n] = 1'b0;
            expPadI[n] = frame[(n - a - 1) / BIT];
            expBusy[n] = 1'b1;
        end
        if (!withRx) expDone[a + 10 * BIT + 1] = 1'b1;
    endtask

    // kind: 0 good byte, 1 timeout, 2 framing error
    task automatic modelRx(input int a, input int d, input int kind, input logic [7:0] data);
        for (int n = a + 1; n < d; n++) expBusy[n] = 1'b1;
        expDone[d] = 1'b1;
        if (kind == 0) begin
            expValid[d] = 1'b1;
            for (int n = d; n < NCYC; n++) expRx[n] = data;
        end else if (kind == 1) begin
            expTo[d] = 1'b1;
        end else begin
            expFr[d] = 1'b1;
        end
    endtask

    function automatic int rxWaitEntry(input int a);
        return a + 10 * BIT + TURN + 1;
    endfunction

    // Line falls at p; seen synchronized SYNC later; detector enters start check next
    // cycle; mid-bit sample BIT/2 later; stop sampled 9 bit times on; result one cycle later.
    function automatic int frameDone(input int p);
        return p + SYNC + 1 + BIT / 2 + 9 * BIT + 1;
    endfunction

    task automatic applyStimulus(input logic [7:0] d, input bit withRx, output int a);
        tick();
        a      = cyc;
        txData = d;
        rxEn   = withRx;
        start  = 1'b1;
        modelTx(a, d, withRx);
        tick();
        start  = 1'b0;
        txData = ~d;
        rxEn   = ~withRx;
    endtask

    task automatic sendFrame(input logic [7:0] d, input bit stopBit);
        logic [9:0] bits;
        bits = {stopBit, d, 1'b0};
        for (int j = 0; j < 10; j++) begin
            respLine = bits[j];
            repeat (BIT) tick();
        end
        respLine = 1'b1;
    endtask

    initial begin
        int a, a2, p, w, g, r, dc, lowCnt;
        logic [9:0] obs, modelPin;
        bit sawValid;

        for (int n = 0; n < NCYC; n++) begin
            expPadT[n] = 1'b1; expPadI[n] = 1'b1; expBusy[n] = 1'b0; expDone[n] = 1'b0;
            expValid[n] = 1'b0; expTo[n] = 1'b0; expFr[n] = 1'b0; expRx[n] = 8'h00;
        end

        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        checkOn = 1'b1;
        checkOutput("reset PAD_T", padT, 1);
        checkOutput("reset PAD_I", padI, 1);
        checkOutput("reset BUSY", busy, 0);
        checkOutput("reset DONE", done, 0);
        checkOutput("reset RX_DATA", rxData, 0);

        // TX only, 8'hA5
        repeat (2) tick();
        applyStimulus(8'hA5, 1'b0, a);
        lowCnt = 0; obs = '0; modelPin = '0; sawValid = 1'b0;
        while (cyc <= a + 170) begin
            int k;
            k = cyc - a - 1;
            if (padT === 1'b0) lowCnt++;
            if (k >= 0 && k < 10 * BIT && (k % BIT) == BIT / 2) begin
                obs[k / BIT]      = padI;
                modelPin[k / BIT] = expPadI[cyc];
            end
            if (rxValid === 1'b1) sawValid = 1'b1;
            tick();
        end
        checkOutput("tx PAD_T low cycles", lowCnt, 160);
        checkOutput("tx PAD_I bit pattern", obs, 10'b1101001010);
        checkOutput("model frame for A5", modelPin, 10'b1101001010);
        checkOutput("tx DONE offset", lastDoneCyc - a, 161);
        checkOutput("tx RX_VALID stays low", sawValid, 0);

        // Round trip 8'h3C, responder starts 10 cycles after release; START mid-TX ignored
        applyStimulus(8'h3C, 1'b1, a);
        p = a + 10 * BIT + 1 + 10;
        modelRx(a, frameDone(p), 0, 8'h3C);
        tickUntil(a + 50);
        start = 1'b1; txData = 8'hFF; rxEn = 1'b0;
        tick();
        start = 1'b0;
        tickUntil(p);
        sendFrame(8'h3C, 1'b1);
        waitDone(a, 200, "round trip done");
        checkOutput("round trip RX_VALID with DONE", lastValid, 1);
        checkOutput("round trip DONE offset", lastDoneCyc - p, 156);
        checkOutput("round trip RX_DATA", rxData, 8'h3C);

        // No answer: timeout
        repeat (3) tick();
        applyStimulus(8'h0F, 1'b1, a);
        w = rxWaitEntry(a);
        modelRx(a, w + TO, 1, 8'h00);
        waitDone(a, 1300, "timeout done");
        checkOutput("timeout ERR_TIMEOUT", lastTo, 1);
        checkOutput("timeout offset from RX_WAIT", lastDoneCyc - w, 1024);
        checkOutput("timeout RX_VALID", lastValid, 0);
        checkOutput("timeout RX_DATA held", rxData, 8'h3C);

        // Glitch then valid 8'h81
        repeat (3) tick();
        applyStimulus(8'h42, 1'b1, a);
        w = rxWaitEntry(a);
        g = w + 20;
        p = w + 75;
        modelRx(a, frameDone(p), 0, 8'h81);
        tickUntil(g);
        respLine = 1'b0;
        repeat (3) tick();
        respLine = 1'b1;
        tickUntil(p);
        sendFrame(8'h81, 1'b1);
        waitDone(a, 200, "glitch done");
        checkOutput("glitch RX_DATA", rxData, 8'h81);
        checkOutput("glitch DONE offset", lastDoneCyc - p, 156);
        checkOutput("glitch RX_VALID", lastValid, 1);

        // Bad stop bit
        repeat (3) tick();
        applyStimulus(8'h99, 1'b1, a);
        p = a + 10 * BIT + 1 + 10;
        modelRx(a, frameDone(p), 2, 8'h00);
        tickUntil(p);
        sendFrame(8'h5A, 1'b0);
        waitDone(a, 200, "bad stop done");
        checkOutput("bad stop ERR_FRAME", lastFr, 1);
        checkOutput("bad stop RX_VALID", lastValid, 0);
        checkOutput("bad stop RX_DATA held", rxData, 8'h81);

        // Reset during data bit 3, then a fresh transmit
        repeat (3) tick();
        applyStimulus(8'hC3, 1'b0, a);
        r = a + 70;
        tickUntil(r);
        rst = 1'b1;
        for (int n = r + 1; n <= a + 10 * BIT + 1; n++) begin
            expPadT[n] = 1'b1; expPadI[n] = 1'b1; expBusy[n] = 1'b0; expDone[n] = 1'b0;
        end
        for (int n = r + 1; n < NCYC; n++) expRx[n] = 8'h00;
        dc = doneCount;
        tick();
        rst = 1'b0;
        checkOutput("abort PAD_T released", padT, 1);
        checkOutput("abort BUSY", busy, 0);
        repeat (30) tick();
        checkOutput("abort no DONE", doneCount, dc);
        checkOutput("abort RX_DATA cleared", rxData, 8'h00);
        applyStimulus(8'h96, 1'b0, a2);
        waitDone(a2, 200, "post-reset tx done");
        checkOutput("post-reset tx DONE offset", lastDoneCyc - a2, 161);

        repeat (5) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/iobuf_hdx_ctrl.md
IOBUF_HDX_CTRL -- requirements
Module: iobuf_hdx_ctrl

Interface
REQ-001 Parameters SHALL be: BIT_CYC, 16, clock cycles per serial bit (even, >=4); TURN_CYC, 4, bus-release cycles between transmit and receive; TO_CYC, 1024, cycles to wait for a response start bit.
REQ-002 C  input  1  clock; all logic on rising edge.
REQ-003 R  input  1  reset, synchronous, active-high.
REQ-004 START  input  1  request a transaction; accepted only in IDLE.
REQ-005 TX_DATA  input  8  byte to transmit; captured when START is accepted.
REQ-006 RX_EN  input  1  response expected; captured when START is accepted.
REQ-007 PAD_I  output  1  value driven to the pad buffer data input.
REQ-008 PAD_T  output  1  pad buffer enable: 0 = drive pad, 1 = release (high-Z).
REQ-009 PAD_O  input  1  pad readback from the pad buffer output; asynchronous.
REQ-010 BUSY  output  1  high whenever the FSM is not in IDLE.
REQ-011 DONE  output  1  one-cycle pulse when a transaction ends.
REQ-012 RX_DATA  output  8  last received byte; held until the next RX_VALID.
REQ-013 RX_VALID  output  1  one-cycle pulse with DONE on a good receive.
REQ-014 ERR_TIMEOUT, ERR_FRAME  output  1 each  one-cycle pulses with DONE.

Function
REQ-015 PAD_O SHALL pass through a 2-flop synchronizer; all receive timing below refers to the synchronized value (S).
REQ-016 States SHALL be IDLE, TX_START, TX_BITS, TX_STOP, TURN, RX_WAIT, RX_START, RX_BITS, RX_STOP.
REQ-017 IDLE: PAD_T=1, PAD_I=1; START=1 SHALL move to TX_START on the next edge and capture TX_DATA and RX_EN.
REQ-018 START while BUSY=1 SHALL be ignored with no effect on the transaction in progress.
REQ-019 TX_START: PAD_T=0, PAD_I=0 for exactly BIT_CYC cycles.
REQ-020 TX_BITS: PAD_T=0; 8 data bits, LSB first, each held BIT_CYC cycles.
REQ-021 TX_STOP: PAD_T=0, PAD_I=1 for BIT_CYC cycles.
REQ-022 After TX_STOP, if captured RX_EN=0, the FSM SHALL return to IDLE and pulse DONE in the first IDLE cycle. If RX_EN=1, it SHALL enter TURN.
REQ-023 TURN: PAD_T=1, PAD_I=1 for TURN_CYC cycles; S ignored; then RX_WAIT.
REQ-024 In RX_WAIT, RX_START, RX_BITS and RX_STOP, PAD_T SHALL be 1.
REQ-025 RX_WAIT: a timeout counter SHALL start at 0 on entry and increment each cycle. S=0 SHALL move to RX_START. When the counter reaches TO_CYC-1 with S=1, the FSM SHALL go to IDLE with DONE and ERR_TIMEOUT.
REQ-026 RX_START: S SHALL be sampled BIT_CYC/2 cycles after entry. S=0 moves to RX_BITS. S=1 is a false start: return to RX_WAIT without resetting the timeout counter.
REQ-027 RX_BITS: 8 samples, each BIT_CYC cycles after the previous, assembled LSB first.
REQ-028 RX_STOP: one sample BIT_CYC cycles after the last data sample. S=1 SHALL update RX_DATA and pulse DONE and RX_VALID. S=0 SHALL pulse DONE and ERR_FRAME, leaving RX_DATA unchanged. The FSM then returns to IDLE.
REQ-029 PAD_T and PAD_I SHALL be registered outputs. PAD_T=0 and PAD_T=1 SHALL never drive contention: PAD_T rises on the same edge that leaves TX_STOP.
REQ-030 Bit and turn counters SHALL be sized to ceil(log2(max(BIT_CYC,TURN_CYC,TO_CYC))) bits, with no wrap inside a state.

Reset
REQ-031 While R=1, on the next edge: state=IDLE, PAD_T=1, PAD_I=1, BUSY=0, DONE=0, RX_VALID=0, ERR_*=0, RX_DATA=8'h00, counters=0, synchronizer flops=1.
REQ-032 R asserted mid-transaction SHALL abort with no DONE pulse; the pad is released from the next edge.

Verification
REQ-033 TX only: TX_DATA=8'hA5, RX_EN=0, START -> PAD_T=0 for 160 cycles, PAD_I pattern 0,1,0,1,0,0,1,0,1,1 per 16 cycles, then DONE; RX_VALID=0.
REQ-034 Round trip: RX_EN=1, model answers 8'h3C frame 10 cycles after release -> RX_DATA=8'h3C, RX_VALID and DONE pulse together.
REQ-035 No answer: RX_EN=1, pad held high -> ERR_TIMEOUT+DONE exactly 1024 cycles after RX_WAIT entry.
REQ-036 Glitch: 3-cycle low pulse in RX_WAIT, then valid 8'h81 frame -> false start ignored, RX_DATA=8'h81.
REQ-037 Bad stop: response stop bit=0 -> ERR_FRAME+DONE, RX_DATA keeps prior value.
REQ-038 R asserted during TX_BITS bit 3 -> PAD_T=1 next cycle, no DONE; a new START then transmits normally.
